// File: rtl/i2c_seq_pkg.sv
// Shared constants for the multi-channel I2C read sequencer: the state encoding,
// the slave address width and the default WAIT timeout.
package i2c_seq_pkg;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DEF_TIMEOUT = 50000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

endpackage

// File: rtl/i2c_seq_pick.sv
// Combinational lowest-set-bit picker: returns the index and the one-hot mask
// of the lowest pending channel.
module i2c_seq_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask_i,
  output logic [CH_W-1:0]   idx_o,
  output logic [NUM_CH-1:0] onehot_o
);

  logic found;

  always_comb begin
    found    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (mask_i[i] && !found) begin
        found       = 1'b1;
        idx_o       = CH_W'(i);
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_multi_read_seq.sv
// Sweeps the enabled channels lowest-first, issuing one read request per channel
// to the I2C system controller and reporting each result with a NACK/timeout flag.
module i2c_multi_read_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*ADDR_W-1:0] addr_tbl,
  output logic                     sys_start,
  output logic [ADDR_W-1:0]        sys_addr,
  input  logic                     sys_done,
  input  logic                     sys_nack,
  input  logic [DATA_W-1:0]        sys_rd_data,
  output logic [NUM_CH-1:0]        bus_sel,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CH_W-1:0]          rd_ch,
  output logic                     valid,
  output logic                     err,
  output logic                     done,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [1:0]                       state_q, state_d;
  logic [NUM_CH-1:0]                pend_q, pend_d;
  logic [NUM_CH-1:0][ADDR_W-1:0]    addr_q, addr_d;
  logic [CH_W-1:0]                  cur_q, cur_d;
  logic [NUM_CH-1:0]                sel_q, sel_d;
  logic [ADDR_W-1:0]                saddr_q, saddr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [DATA_W-1:0]                rdata_q, rdata_d;
  logic [CH_W-1:0]                  rch_q, rch_d;
  logic                             valid_q, valid_d;
  logic                             err_q, err_d;
  logic                             done_q, done_d;
  logic                             finish;
  logic [CH_W-1:0]                  pick_idx;
  logic [NUM_CH-1:0]                pick_oh;

  i2c_seq_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .mask_i   (pend_q),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    cur_d   = cur_q;
    sel_d   = sel_q;
    saddr_d = saddr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rch_d   = rch_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (|ch_en) begin
            pend_d  = ch_en;
            addr_d  = addr_tbl;
            state_d = ST_SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        cur_d   = pick_idx;
        pend_d  = pend_q & ~pick_oh;
        saddr_d = addr_q[pick_idx];
        sel_d   = pick_oh;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      default: begin
        // A completion on the very cycle the timeout expires still counts as a real response.
        if (sys_done) begin
          finish  = 1'b1;
          err_d   = sys_nack;
          rdata_d = sys_nack ? '0 : sys_rd_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (finish) begin
          valid_d = 1'b1;
          rch_d   = cur_q;
          if (|pend_q) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            sel_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      cur_q   <= '0;
      sel_q   <= '0;
      saddr_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rch_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      cur_q   <= cur_d;
      sel_q   <= sel_d;
      saddr_q <= saddr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rch_q   <= rch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign sys_start = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);
  assign sys_addr  = saddr_q;
  assign bus_sel   = sel_q;
  assign rd_data   = rdata_q;
  assign rd_ch     = rch_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_i2c_multi_read_seq.sv
// Scoreboard bench for i2c_multi_read_seq: a reference model queues the expected
// request/result sequence per sweep; a monitor checks the DUT against it.
module tb_i2c_multi_read_seq;

  localparam int TO = 100;

  typedef struct {
    int         ch;
    logic [6:0] addr;
    logic [3:0] sel;
    logic       err;
    logic [7:0] data;
    logic       last;
    int         delta;
  } exp_t;

  typedef struct {
    bit         silent;
    bit         nack;
    logic [7:0] data;
    int         lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ch_en;
  logic [27:0] addr_tbl;
  logic        sys_start;
  logic [6:0]  sys_addr;
  logic        sys_done;
  logic        sys_nack;
  logic [7:0]  sys_rd_data;
  logic [3:0]  bus_sel;
  logic [7:0]  rd_data;
  logic [1:0]  rd_ch;
  logic        valid;
  logic        err;
  logic        done;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   pending_empty = 0;
  exp_t exp_q[$];
  rsp_t resp_q[$];
  rsp_t plan[4];

  i2c_multi_read_seq #(
    .NUM_CH  (4),
    .DATA_W  (8),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_en       (ch_en),
    .addr_tbl    (addr_tbl),
    .sys_start   (sys_start),
    .sys_addr    (sys_addr),
    .sys_done    (sys_done),
    .sys_nack    (sys_nack),
    .sys_rd_data (sys_rd_data),
    .bus_sel     (bus_sel),
    .rd_data     (rd_data),
    .rd_ch       (rd_ch),
    .valid       (valid),
    .err         (err),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: channels served lowest index first, one result each.
  task automatic push_plan(input logic [3:0] mask, input logic [27:0] tbl);
    int   hi = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) if (mask[i]) hi = i;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        e.ch   = i;
        e.addr = tbl[7*i +: 7];
        e.sel  = 4'(1 << i);
        e.last = (i == hi);
        if (plan[i].silent) begin
          e.err   = 1'b1;
          e.data  = 8'h00;
          e.delta = TO;
        end else begin
          e.err   = plan[i].nack;
          e.data  = plan[i].nack ? 8'h00 : plan[i].data;
          e.delta = plan[i].lat + 1;
        end
        exp_q.push_back(e);
        resp_q.push_back(plan[i]);
      end
    end
  endtask

  // Slave/controller model: answers each request after its planned latency.
  initial begin
    rsp_t r;
    sys_done    = 1'b0;
    sys_nack    = 1'b0;
    sys_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && sys_start && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (!r.silent) begin
          repeat (r.lat) @(posedge clk);
          #1;
          sys_done    = 1'b1;
          sys_nack    = r.nack;
          sys_rd_data = r.data;
          @(posedge clk);
          #1;
          sys_done    = 1'b0;
          sys_nack    = 1'b0;
          sys_rd_data = 8'($urandom);
        end
      end
    end
  end

  // Monitor: compares every request and every result against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (sys_start) begin
        if (exp_q.size() == 0) chk("spurious_sys_start", sys_start, 0);
        else begin
          chk("sys_addr", sys_addr, exp_q[0].addr);
          chk("bus_sel", bus_sel, exp_q[0].sel);
          start_cyc = cyc;
        end
      end
      if (valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", valid, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_ch", rd_ch, e.ch);
          chk("err", err, e.err);
          chk("rd_data", rd_data, e.data);
          chk("done_with_valid", done, e.last);
          chk("result_latency", cyc - start_cyc, e.delta);
        end
      end else if (done) begin
        if (pending_empty > 0) pending_empty--;
        else chk("spurious_done", done, 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sys_start"}, sys_start, 0);
    chk({tag, "_sys_addr"}, sys_addr, 0);
    chk({tag, "_bus_sel"}, bus_sel, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_ch"}, rd_ch, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic sweep(input logic [3:0] mask, input logic [27:0] tbl, input bit disturb);
    bit finished = 1'b0;
    @(posedge clk);
    #1;
    push_plan(mask, tbl);
    start    = 1'b1;
    ch_en    = mask;
    addr_tbl = tbl;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    @(posedge clk);
    #1;
    chk("sys_start_latency", sys_start, 1);
    for (int c = 0; c < 600 && !finished; c++) begin
      @(negedge clk);
      if (disturb) begin
        if (busy && !done) begin
          start    = 1'($urandom);
          ch_en    = 4'($urandom);
          addr_tbl = 28'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      if (!busy && exp_q.size() == 0) finished = 1'b1;
    end
    start = 1'b0;
    chk("sweep_completed", finished, 1);
  endtask

  task automatic empty_sweep();
    @(posedge clk);
    #1;
    pending_empty++;
    start = 1'b1;
    ch_en = 4'b0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("empty_done_single", done, 0);
  endtask

  task automatic rand_plan();
    for (int i = 0; i < 4; i++) begin
      plan[i].silent = ($urandom_range(0, 9) == 0);
      plan[i].nack   = ($urandom_range(0, 3) == 0);
      plan[i].data   = 8'($urandom);
      plan[i].lat    = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(1, 12);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    ch_en    = 4'b0000;
    addr_tbl = 28'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Basic two-channel sweep with known addresses and data.
    plan[0] = '{silent: 1'b0, nack: 1'b0, data: 8'h12, lat: 3};
    plan[2] = '{silent: 1'b0, nack: 1'b0, data: 8'h90, lat: 5};
    sweep(4'b0101, {7'h00, 7'h20, 7'h00, 7'h10}, 1'b0);

    empty_sweep();

    // NACK on the second channel.
    plan[0] = '{silent: 1'b0, nack: 1'b0, data: 8'h33, lat: 2};
    plan[1] = '{silent: 1'b0, nack: 1'b1, data: 8'h5A, lat: 4};
    sweep(4'b0011, {7'h00, 7'h00, 7'h41, 7'h40}, 1'b0);

    // Timeout on ch1, then ch2 answers on the last possible cycle.
    plan[1] = '{silent: 1'b1, nack: 1'b0, data: 8'hEE, lat: 1};
    plan[2] = '{silent: 1'b0, nack: 1'b0, data: 8'hC3, lat: TO - 1};
    sweep(4'b0110, {7'h00, 7'h55, 7'h2A, 7'h00}, 1'b0);

    // Minimum latency, single high channel, with disturbance on start/ch_en.
    plan[3] = '{silent: 1'b0, nack: 1'b0, data: 8'hA5, lat: 1};
    sweep(4'b1000, {7'h7F, 7'h01, 7'h02, 7'h03}, 1'b1);

    for (int n = 0; n < 20; n++) begin
      rand_plan();
      sweep(4'($urandom_range(1, 15)), 28'($urandom), 1'($urandom));
      if (n % 5 == 0) empty_sweep();
    end

    // Asynchronous reset while waiting on a silent slave.
    plan[0] = '{silent: 1'b1, nack: 1'b0, data: 8'h00, lat: 1};
    @(posedge clk);
    #1;
    push_plan(4'b0001, {7'h00, 7'h00, 7'h00, 7'h66});
    start    = 1'b1;
    ch_en    = 4'b0001;
    addr_tbl = {7'h00, 7'h00, 7'h00, 7'h66};
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("midwait_reset");
    exp_q.delete();
    resp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    plan[0] = '{silent: 1'b0, nack: 1'b0, data: 8'h5C, lat: 6};
    sweep(4'b0001, {7'h00, 7'h00, 7'h00, 7'h19}, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("leftover_expectations", exp_q.size(), 0);
    chk("leftover_empty_done", pending_empty, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_multi_read_seq.md
I2C_MULTI_READ_SEQ -- requirements
Module: i2c_multi_read_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of slave channels (1..8).
REQ-002 Parameter DATA_W, default 8, read-data width.
REQ-003 Parameter TIMEOUT, default 50000, maximum WAIT cycles per channel (>=2).
REQ-004 Parameter CH_W, default $clog2(NUM_CH) (min 1), channel-index width.
REQ-005 Reset rst, asynchronous, active-high; clock clk.
REQ-006 Ports SHALL be:
  clk  in  1  clock.
  rst  in  1  async active-high reset.
  start  in  1  begins one sweep; sampled in IDLE only.
  ch_en  in  NUM_CH  channel enable mask; latched at start.
  addr_tbl  in  NUM_CH*7  slave addresses, ch i at [7i+6:7i]; latched at start.
  sys_start  out  1  one-cycle request to the I2C system controller.
  sys_addr  out  7  slave address for the current request.
  sys_done  in  1  controller completion pulse.
  sys_nack  in  1  slave NACK flag, qualified by sys_done.
  sys_rd_data  in  DATA_W  read byte, qualified by sys_done.
  bus_sel  out  NUM_CH  one-hot bus-segment select for time-multiplexing.
  rd_data  out  DATA_W  result byte.
  rd_ch  out  CH_W  channel index of rd_data.
  valid  out  1  one-cycle result strobe.
  err  out  1  qualified by valid: NACK or timeout.
  done  out  1  one-cycle end-of-sweep strobe.
  busy  out  1  high in every state except IDLE.

Function
REQ-007 FSM states SHALL be IDLE, SCAN, ISSUE, WAIT; all outputs SHALL be registered or decoded from registered state.
REQ-008 IDLE with start=1 and ch_en!=0 SHALL latch ch_en to pend_mask and addr_tbl to addr_q, then go to SCAN.
REQ-009 IDLE with start=1 and ch_en==0 SHALL pulse done the next cycle, with no valid and no sys_start, and remain in IDLE.
REQ-010 SCAN SHALL select cur_ch = the lowest set bit of pend_mask, clear that bit, load sys_addr from addr_q[cur_ch], set bus_sel=1<<cur_ch, and go to ISSUE.
REQ-011 sys_start SHALL be high exactly during the ISSUE state (one cycle), i.e. two clocks after the start sample edge for the first channel.
REQ-012 ISSUE SHALL clear the timeout counter and go to WAIT.
REQ-013 WAIT with sys_done=1 SHALL register valid=1, rd_ch=cur_ch, err=sys_nack, and rd_data=sys_rd_data (0 if sys_nack).
REQ-014 The timeout counter SHALL increment each WAIT cycle; when it reaches TIMEOUT-1 with sys_done=0, WAIT SHALL register valid=1, err=1, rd_data=0.
REQ-015 If sys_done and timeout coincide, sys_done SHALL take priority.
REQ-016 On WAIT exit, the FSM SHALL go to SCAN if pend_mask!=0; otherwise it SHALL go to IDLE and assert done in the same cycle as the final valid.
REQ-017 valid, err and done SHALL be single-cycle pulses; rd_data and rd_ch SHALL hold until the next valid.
REQ-018 bus_sel SHALL hold from SCAN through WAIT exit and SHALL be 0 in IDLE; sys_addr SHALL hold its last value.
REQ-019 start outside IDLE, and sys_done outside WAIT, SHALL be ignored; changes to ch_en or addr_tbl during a sweep SHALL have no effect.
REQ-020 A NACK or timeout SHALL NOT abort the sweep; the remaining channels SHALL still be read.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, pend_mask=0, counter=0, and every output to 0, including mid-transaction.
REQ-022 The first start after rst deassertion SHALL behave per REQ-008.

Structure
REQ-023 Package i2c_seq_pkg SHALL hold the state encoding, the 7-bit address width constant, and the default TIMEOUT.
REQ-024 The lowest-set-bit picker SHALL be the combinational sub-module i2c_seq_pick (mask in; index and one-hot out).

Verification
REQ-025 NUM_CH=4, ch_en=0101, ch0=0x10, ch2=0x20, model returns 0x12 then 0x90 -> sys_addr 0x10 then 0x20; bus_sel 0001 then 0100; valid pulses with rd_ch 0 then 2 and data 0x12 then 0x90, err=0; done coincident with the second valid.
REQ-026 ch_en=0000 with start -> done one cycle later; sys_start never asserted.
REQ-027 ch_en=0011, ch1 returns sys_nack=1 -> second valid has err=1, rd_data=0x00, rd_ch=1; done asserted.
REQ-028 TIMEOUT=100, model never returns sys_done -> valid with err=1 exactly 100 cycles after the sys_start pulse; sweep continues to the next channel.
REQ-029 rst pulsed mid-WAIT -> all outputs 0 in the same cycle; a subsequent start with ch_en=0001 completes normally.
REQ-030 start re-pulsed and ch_en changed mid-sweep -> no extra sys_start; the result sequence is unchanged.
